// File: rtl/traffic_light_ctrl_p.sv
// Two-road intersection controller with protected left turns,
// an internal phase timer and a flashing-red maintenance mode.
module traffic_light_ctrl_p #(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned T_ALLRED     = 50_000_000,
  parameter int unsigned T_GREEN_MAIN = 500_000_000,
  parameter int unsigned T_GREEN_SIDE = 300_000_000,
  parameter int unsigned T_YEL        = 100_000_000,
  parameter int unsigned T_LFT_GRE    = 150_000_000,
  parameter int unsigned T_LFT_YEL    = 50_000_000,
  parameter int unsigned T_FLASH      = 50_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flash_en,
  input  logic       main_left_req,
  input  logic       side_left_req,
  output logic [3:0] state,
  output logic [3:0] main_face1,
  output logic [3:0] main_face2,
  output logic [3:0] side_face1,
  output logic [3:0] side_face2,
  output logic       phase_done
);

  typedef enum logic [3:0] {
    RR1   = 4'd0,
    MLG   = 4'd1,
    MLY   = 4'd2,
    MG    = 4'd3,
    MY    = 4'd4,
    RR2   = 4'd5,
    SLG   = 4'd6,
    SLY   = 4'd7,
    SG    = 4'd8,
    SY    = 4'd9,
    FLASH = 4'd10
  } state_e;

  localparam logic [3:0] F_GRE    = 4'd0;
  localparam logic [3:0] F_YEL    = 4'd1;
  localparam logic [3:0] F_RED    = 4'd2;
  localparam logic [3:0] F_LFTGRE = 4'd3;
  localparam logic [3:0] F_LFTYEL = 4'd4;
  localparam logic [3:0] F_ALLOFF = 4'd5;

  localparam logic [CNT_W-1:0] L_ALLRED = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] L_GM     = CNT_W'(T_GREEN_MAIN - 1);
  localparam logic [CNT_W-1:0] L_GS     = CNT_W'(T_GREEN_SIDE - 1);
  localparam logic [CNT_W-1:0] L_YEL    = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] L_LG     = CNT_W'(T_LFT_GRE - 1);
  localparam logic [CNT_W-1:0] L_LY     = CNT_W'(T_LFT_YEL - 1);
  localparam logic [CNT_W-1:0] L_FLASH  = CNT_W'(T_FLASH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] timer_q;
  logic             main_pend_q;
  logic             side_pend_q;
  logic             flash_phase_q;

  logic dn;
  logic legal;
  logic into_mlg;
  logic into_slg;
  logic main_set;
  logic side_set;

  // Reload value for the timer on entry into a timed state.
  function automatic logic [CNT_W-1:0] load_of(input state_e s);
    logic [CNT_W-1:0] v;
    case (s)
      MLG, SLG: v = L_LG;
      MLY, SLY: v = L_LY;
      MG:       v = L_GM;
      SG:       v = L_GS;
      MY, SY:   v = L_YEL;
      default:  v = L_ALLRED;
    endcase
    return v;
  endfunction

  // Successor of a timed state when its timer expires.
  function automatic state_e next_of(
    input state_e s,
    input logic   mp,
    input logic   sp
  );
    state_e n;
    case (s)
      RR1:     n = mp ? MLG : MG;
      MLG:     n = MLY;
      MLY:     n = MG;
      MG:      n = MY;
      MY:      n = RR2;
      RR2:     n = sp ? SLG : SG;
      SLG:     n = SLY;
      SLY:     n = SG;
      SG:      n = SY;
      default: n = RR1;
    endcase
    return n;
  endfunction

  assign dn       = (timer_q == '0);
  assign legal    = (state_q <= FLASH);
  assign into_mlg = !flash_en && state_q == RR1 && dn && main_pend_q;
  assign into_slg = !flash_en && state_q == RR2 && dn && side_pend_q;
  assign main_set = main_left_req && state_q != MLG && state_q != MLY;
  assign side_set = side_left_req && state_q != SLG && state_q != SLY;

  assign state      = state_q;
  assign phase_done = dn && legal && state_q != FLASH;

  // Sequencer: state, phase timer, left-turn pending flags, flash phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RR1;
      timer_q       <= L_ALLRED;
      main_pend_q   <= 1'b0;
      side_pend_q   <= 1'b0;
      flash_phase_q <= 1'b0;
    end else begin
      main_pend_q <= (main_pend_q | main_set) & ~into_mlg;
      side_pend_q <= (side_pend_q | side_set) & ~into_slg;
      if (flash_en) begin
        if (state_q != FLASH) begin
          state_q       <= FLASH;
          timer_q       <= L_FLASH;
          flash_phase_q <= 1'b0;
        end else if (dn) begin
          timer_q       <= L_FLASH;
          flash_phase_q <= ~flash_phase_q;
        end else begin
          timer_q <= timer_q - 1'b1;
        end
      end else if (state_q == FLASH || !legal) begin
        state_q       <= RR1;
        timer_q       <= L_ALLRED;
        flash_phase_q <= 1'b0;
      end else if (dn) begin
        state_q <= next_of(state_q, main_pend_q, side_pend_q);
        timer_q <= load_of(next_of(state_q, main_pend_q, side_pend_q));
      end else begin
        timer_q <= timer_q - 1'b1;
      end
    end
  end

  // Face decode straight from the state register; unlisted faces stay red.
  always_comb begin
    main_face1 = F_RED;
    main_face2 = F_RED;
    side_face1 = F_RED;
    side_face2 = F_RED;
    case (state_q)
      MG: begin
        main_face1 = F_GRE;
        main_face2 = F_GRE;
      end
      MY: begin
        main_face1 = F_YEL;
        main_face2 = F_YEL;
      end
      MLG: main_face2 = F_LFTGRE;
      MLY: main_face2 = F_LFTYEL;
      SG: begin
        side_face1 = F_GRE;
        side_face2 = F_GRE;
      end
      SY: begin
        side_face1 = F_YEL;
        side_face2 = F_YEL;
      end
      SLG: side_face2 = F_LFTGRE;
      SLY: side_face2 = F_LFTYEL;
      FLASH: begin
        main_face1 = flash_phase_q ? F_ALLOFF : F_RED;
        main_face2 = flash_phase_q ? F_ALLOFF : F_RED;
        side_face1 = flash_phase_q ? F_ALLOFF : F_RED;
        side_face2 = flash_phase_q ? F_ALLOFF : F_RED;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl_p.sv
// Bench for traffic_light_ctrl_p: directed scenarios plus random
// requests/flash, checked against a phase-table reference model.
module tb_traffic_light_ctrl_p;

  localparam int RR1 = 0, MLG = 1, MLY = 2, MG = 3, MY = 4;
  localparam int RR2 = 5, SLG = 6, SLY = 7, SG = 8, SY = 9;
  localparam int FLS = 10;

  logic       clk;
  logic       reset_n;
  logic       flash_en;
  logic       main_left_req;
  logic       side_left_req;
  logic [3:0] state;
  logic [3:0] main_face1;
  logic [3:0] main_face2;
  logic [3:0] side_face1;
  logic [3:0] side_face2;
  logic       phase_done;

  int n_cmp = 0;
  int n_bad = 0;

  int dur[11]  = '{2, 4, 2, 5, 3, 2, 4, 2, 4, 3, 3};
  int succ[11] = '{0, 2, 3, 4, 5, 0, 7, 8, 9, 0, 0};

  int ms;
  int me;
  bit fph;
  bit mp;
  bit sp;
  int fl_left;

  traffic_light_ctrl_p #(
    .CNT_W(8), .T_ALLRED(2), .T_GREEN_MAIN(5), .T_GREEN_SIDE(4),
    .T_YEL(3), .T_LFT_GRE(4), .T_LFT_YEL(2), .T_FLASH(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flash_en(flash_en),
    .main_left_req(main_left_req), .side_left_req(side_left_req),
    .state(state), .main_face1(main_face1), .main_face2(main_face2),
    .side_face1(side_face1), .side_face2(side_face2),
    .phase_done(phase_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)",
             tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    ms = RR1; me = 0; fph = 0; mp = 0; sp = 0;
  endtask

  task automatic check_all();
    int f[4];
    for (int i = 0; i < 4; i++) f[i] = 2;
    case (ms)
      MG:  begin f[0] = 0; f[1] = 0; end
      MY:  begin f[0] = 1; f[1] = 1; end
      MLG: f[1] = 3;
      MLY: f[1] = 4;
      SG:  begin f[2] = 0; f[3] = 0; end
      SY:  begin f[2] = 1; f[3] = 1; end
      SLG: f[3] = 3;
      SLY: f[3] = 4;
      FLS: for (int i = 0; i < 4; i++) f[i] = fph ? 5 : 2;
      default: ;
    endcase
    chk("state", 32'(state), ms);
    chk("main_face1", 32'(main_face1), f[0]);
    chk("main_face2", 32'(main_face2), f[1]);
    chk("side_face1", 32'(side_face1), f[2]);
    chk("side_face2", 32'(side_face2), f[3]);
    chk("phase_done", 32'(phase_done),
        32'((me == dur[ms] - 1) && ms != FLS));
    chk("main_pend", 32'(dut.main_pend_q), 32'(mp));
    chk("side_pend", 32'(dut.side_pend_q), 32'(sp));
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic step(input bit fe, input bit mr, input bit sr);
    bit last = (me == dur[ms] - 1);
    bit mset = mr && ms != MLG && ms != MLY;
    bit sset = sr && ms != SLG && ms != SLY;
    bit mclr = 0;
    bit sclr = 0;
    int nx;
    if (fe) begin
      if (ms != FLS) begin ms = FLS; me = 0; fph = 0; end
      else if (last) begin me = 0; fph = !fph; end
      else me++;
    end else if (ms == FLS) begin
      ms = RR1; me = 0; fph = 0;
    end else if (last) begin
      if (ms == RR1) nx = mp ? MLG : MG;
      else if (ms == RR2) nx = sp ? SLG : SG;
      else nx = succ[ms];
      mclr = (nx == MLG);
      sclr = (nx == SLG);
      ms = nx; me = 0;
    end else begin
      me++;
    end
    mp = (mp | mset) & !mclr;
    sp = (sp | sset) & !sclr;
  endtask

  // Called at a negedge: check, drive inputs, advance model, wait.
  task automatic cycle(input bit fe, input bit mr, input bit sr);
    check_all();
    flash_en = fe;
    main_left_req = mr;
    side_left_req = sr;
    step(fe, mr, sr);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    flash_en = 1'b0;
    main_left_req = 1'b0;
    side_left_req = 1'b0;
    model_reset();
    fl_left = 0;
    repeat (3) @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // Free-running sequence, no requests
    for (int k = 0; k < 45; k++) cycle(0, 0, 0);

    // One-cycle main left request during MG
    for (int k = 0; k < 40 && ms != MG; k++) cycle(0, 0, 0);
    cycle(0, 1, 0);
    for (int k = 0; k < 50; k++) cycle(0, 0, 0);

    // Side left request held high
    for (int k = 0; k < 60; k++) cycle(0, 0, 1);

    // Flash mode entered mid-MG, then dropped
    for (int k = 0; k < 40 && ms != MG; k++) cycle(0, k == 0, 0);
    cycle(0, 0, 0);
    for (int k = 0; k < 14; k++) cycle(1, 0, 0);
    for (int k = 0; k < 30; k++) cycle(0, 0, 0);

    // Asynchronous reset in the middle of SLY
    for (int k = 0; k < 60 && ms != SLY; k++)
      cycle(0, ms == SLG, 1);
    check_all();
    flash_en = 1'b0;
    main_left_req = 1'b0;
    side_left_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    for (int k = 0; k < 25; k++) cycle(0, 0, 0);

    // Random requests and flash bursts
    for (int k = 0; k < 800; k++) begin
      if (fl_left > 0) fl_left--;
      else if ($urandom_range(0, 59) == 0) fl_left = $urandom_range(3, 12);
      cycle(fl_left > 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 14) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
